// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the sequential priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

endpackage

// File: rtl/prio_pick.sv
// Combinational priority picker: lowest set bit, or first set bit at/above ptr
// with wrap-around in round-robin mode.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IW    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [IW-1:0]    ptr_i,
  input  logic             mode_i,
  output logic [IW-1:0]    idx_o,
  output logic             any_o,
  output logic [WIDTH-1:0] onehot_o
);

  logic [WIDTH-1:0] upper;
  logic             rr_en;

  function automatic logic [IW-1:0] lowest(input logic [WIDTH-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (v[i]) r = IW'(i);
    end
    return r;
  endfunction

  // Round-robin searches bits at/above ptr first, then falls back to the whole vector.
  always_comb begin
    rr_en = (mode_i == 1'(PRIO_RR));
    upper = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      upper[i] = vec_i[i] & (i >= 32'(ptr_i));
    end
    if (rr_en && (upper != '0)) idx_o = lowest(upper);
    else                        idx_o = lowest(vec_i);
    any_o    = |vec_i;
    onehot_o = any_o ? (WIDTH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: accepts a request vector and emits one index
// beat per set bit (or a single empty beat), with valid/ready on both sides.
module prio_enc_seq
  import prio_enc_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned MODE  = PRIO_FIXED,
  localparam int unsigned IW    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IW-1:0]    idx_o,
  output logic             any_o,
  output logic             last_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [IW-1:0]    ptr_q, ptr_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_onehot;
  logic             busy;
  logic             single;

  prio_pick #(.WIDTH(WIDTH)) u_pick (
    .vec_i    (pend_q),
    .ptr_i    (ptr_q),
    .mode_i   (1'(MODE == PRIO_RR)),
    .idx_o    (pick_idx),
    .any_o    (pick_any),
    .onehot_o (pick_onehot)
  );

  // Outputs are gated to zero outside BUSY so nothing leaks between vectors.
  always_comb begin
    busy        = (state_q == BUSY);
    single      = ((pend_q & (pend_q - WIDTH'(1))) == '0);
    req_ready_o = !busy;
    out_valid_o = busy;
    idx_o       = busy ? pick_idx : '0;
    any_o       = busy & pick_any;
    last_o      = busy & single;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          pend_d  = req_i;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_ready_i) begin
          pend_d = pend_q & ~pick_onehot;
          if (single) state_d = IDLE;
          // Pointer advances past the granted bit, wrapping at WIDTH.
          if ((MODE == PRIO_RR) && pick_any) begin
            ptr_d = (32'(pick_idx) == WIDTH - 1) ? '0 : pick_idx + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_prio_enc_seq.sv
// Bench for prio_enc_seq: three configurations checked every cycle against a
// behavioural model, plus directed vectors with literal beat lists.
module tb_prio_enc_seq;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [NI];
  logic [7:0] req       [NI];
  logic       out_ready [NI];
  logic       req_ready [NI];
  logic       out_valid [NI];
  logic [2:0] idx       [NI];
  logic       any_v     [NI];
  logic       last_v    [NI];

  int total = 0;
  int bad   = 0;

  // Model configuration and state per instance.
  int         wid    [NI] = '{8, 8, 5};
  int         mode_m [NI] = '{0, 1, 1};
  logic [7:0] pend_m [NI];
  logic       busy_m [NI];
  int         ptr_m  [NI];

  int log_q [$];
  int exp_q [$];

  always #5 clk = ~clk;

  prio_enc_seq #(.WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_i(req[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .idx_o(idx[0]), .any_o(any_v[0]), .last_o(last_v[0])
  );

  prio_enc_seq #(.WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_i(req[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .idx_o(idx[1]), .any_o(any_v[1]), .last_o(last_v[1])
  );

  prio_enc_seq #(.WIDTH(5), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_i(req[2][4:0]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .idx_o(idx[2]), .any_o(any_v[2]), .last_o(last_v[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // First set bit scanning upward from ptr with wrap; ptr is 0 in fixed mode.
  function automatic int pick(input logic [7:0] p, input int ptr, input int w);
    for (int k = 0; k < w; k++) begin
      if (p[(ptr + k) % w]) return (ptr + k) % w;
    end
    return 0;
  endfunction

  function automatic logic [7:0] wmask(input int w);
    return (w >= 8) ? 8'hFF : 8'((1 << w) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        busy_m[i] <= 1'b0;
        pend_m[i] <= '0;
        ptr_m[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (!busy_m[i]) begin
          if (req_valid[i]) begin
            pend_m[i] <= req[i] & wmask(wid[i]);
            busy_m[i] <= 1'b1;
          end
        end else if (out_ready[i]) begin
          pend_m[i] <= pend_m[i] & ~(8'd1 << pick(pend_m[i], ptr_m[i], wid[i]));
          busy_m[i] <= ($countones(pend_m[i]) > 1);
          if (mode_m[i] == 1 && pend_m[i] != 0)
            ptr_m[i] <= (pick(pend_m[i], ptr_m[i], wid[i]) + 1) % wid[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_ready", i), int'(req_ready[i]), int'(!busy_m[i]));
      chk($sformatf("u%0d_valid", i), int'(out_valid[i]), int'(busy_m[i]));
      chk($sformatf("u%0d_any", i), int'(any_v[i]), int'(busy_m[i] && pend_m[i] != 0));
      chk($sformatf("u%0d_idx", i), int'(idx[i]),
          (busy_m[i] && pend_m[i] != 0) ? pick(pend_m[i], ptr_m[i], wid[i]) : 0);
      chk($sformatf("u%0d_last", i), int'(last_v[i]),
          int'(busy_m[i] && $countones(pend_m[i]) <= 1));
      if (out_valid[i] && out_ready[i])
        log_q.push_back(i * 1000 + int'(any_v[i]) * 100 + int'(last_v[i]) * 10 + int'(idx[i]));
    end
  end

  task automatic expect_log(input string nm);
    chk({nm, "_nbeats"}, log_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++)
      chk($sformatf("%s_beat%0d", nm, j), log_q[j], exp_q[j]);
    log_q.delete();
    exp_q.delete();
  endtask

  // Offer one vector, optionally stall the consumer, and wait for its last beat.
  task automatic run_vec(input int i, input logic [7:0] v, input int stall, input bit hold);
    bit seen;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req[i]       = v;
    out_ready[i] = (stall == 0);
    @(posedge clk); #1;
    if (!hold) req_valid[i] = 1'b0;
    req[i] = 8'($urandom);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready[i] = 1'b1;
    end
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid[i] && out_ready[i] && last_v[i];
    end
    chk($sformatf("u%0d_last_seen", i), int'(seen), 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    chk($sformatf("u%0d_rdy_after_last", i), int'(req_ready[i]), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req[i]       = '0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(req_ready[0]), 1);
    chk("rst_valid", int'(out_valid[0]), 0);
    chk("rst_idx", int'(idx[0]), 0);
    chk("rst_any", int'(any_v[0]), 0);
    chk("rst_last", int'(last_v[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();

    run_vec(0, 8'b1010_0100, 0, 1'b0);
    exp_q = '{102, 105, 117};
    expect_log("fixed_a4");

    run_vec(0, 8'b0000_0011, 3, 1'b0);
    exp_q = '{100, 111};
    expect_log("fixed_bp");

    run_vec(0, 8'h00, 0, 1'b0);
    exp_q = '{10};
    expect_log("fixed_zero");

    run_vec(1, 8'b1000_0001, 0, 1'b0);
    exp_q = '{1100, 1117};
    expect_log("rr_81_first");
    chk("rr_ptr_wrap", ptr_m[1], 0);
    run_vec(1, 8'b1000_0001, 0, 1'b0);
    exp_q = '{1100, 1117};
    expect_log("rr_81_second");

    run_vec(1, 8'b0000_0100, 0, 1'b0);
    exp_q = '{1112};
    expect_log("rr_set_ptr");
    chk("rr_ptr3", ptr_m[1], 3);
    run_vec(1, 8'b0001_0001, 0, 1'b0);
    exp_q = '{1104, 1110};
    expect_log("rr_11_ptr3");

    run_vec(2, 8'h1F, 0, 1'b1);
    exp_q = '{2100, 2101, 2102, 2103, 2114};
    expect_log("w5_all");
    chk("w5_ptr_end", ptr_m[2], 0);

    run_vec(1, 8'h00, 0, 1'b0);
    exp_q = '{1010};
    expect_log("rr_zero");

    // Reset pulsed after the first of three beats.
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req[1]       = 8'b0000_1011;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #2;
    chk("mid_one_beat", log_q.size(), 1);
    log_q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", int'(out_valid[1]), 0);
    chk("mid_async_ready", int'(req_ready[1]), 1);
    chk("mid_async_last", int'(last_v[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    expect_log("mid_after_release");

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req[i]       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) req_valid[i] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_enc_seq.md
PRIO_ENC_SEQ -- requirements
Module: prio_enc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, request vector width (legal range 2..64, not required to be a power of two).
REQ-002 SHALL have parameter MODE, default 0, selecting 0 = fixed priority (bit 0 highest) or 1 = round-robin.
REQ-003 SHALL define derived localparam IW = max(1, clog2(WIDTH)), the index width.
REQ-004 SHALL have the ports listed below, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_valid_i  input  1  request vector offered.
- req_ready_o  output  1  block can accept a vector.
- req_i  input  WIDTH  request bit vector.
- out_valid_o  output  1  index beat valid.
- out_ready_i  input  1  consumer accepts beat.
- idx_o  output  IW  encoded index of the granted bit.
- any_o  output  1  beat carries a real index; 0 for an empty vector.
- last_o  output  1  final beat of the current vector.
REQ-005 SHALL state the decided interface facts exactly: one clock; reset is asynchronous and active-low.

Function
REQ-006 SHALL implement two states: IDLE and BUSY.
REQ-007 SHALL drive req_ready_o = 1 only in IDLE, combinationally from state.
REQ-008 SHALL, in IDLE on req_valid_i & req_ready_o, register req_i into a pending vector and enter BUSY at the same edge.
REQ-009 SHALL assert out_valid_o in the cycle after acceptance, giving 1-cycle latency; out_valid_o SHALL be 1 throughout BUSY.
REQ-010 SHALL compute idx_o combinationally from the pending vector and search pointer, as follows:
- MODE 0: lowest set bit.
- MODE 1: first set bit at or above ptr, wrapping from WIDTH-1 to 0.
REQ-011 SHALL drive last_o = 1 when the pending vector has at most one bit set.
REQ-012 SHALL, on each beat where out_valid_o & out_ready_i, clear the pending bit at idx_o; the next index SHALL be visible in the following cycle.
REQ-013 SHALL hold idx_o, any_o and last_o stable while out_valid_o & !out_ready_i.
REQ-014 SHALL, on the handshake of a beat with last_o = 1, return to IDLE; req_ready_o SHALL be 1 the next cycle, giving one bubble between vectors.
REQ-015 SHALL emit an all-zero vector as a single beat with any_o = 0, idx_o = 0, last_o = 1.
REQ-016 SHALL, in MODE 1, load ptr = (idx_o + 1) mod WIDTH on every handshake with any_o = 1, including wrap from WIDTH-1 to 0.
REQ-017 SHALL persist ptr across vectors in MODE 1; in MODE 0, ptr SHALL stay 0 and be unused.
REQ-018 SHALL ignore req_valid_i and req_i while in BUSY.
REQ-019 SHALL drive idx_o, any_o and last_o to 0 while out_valid_o = 0 and never output X.

Reset
REQ-020 SHALL, on rst_n low and regardless of clk, force:
- state to IDLE;
- pending vector and ptr to 0;
- out_valid_o, idx_o, any_o and last_o to 0;
- req_ready_o to 1.
REQ-021 SHALL, on reset asserted mid-vector, abandon all remaining pending bits with no further beats after release.
REQ-022 SHALL deassert reset synchronously through external synchroniser logic; the block SHALL only assume async assertion.

Structure
REQ-023 SHALL place in shared package prio_enc_pkg:
- the state enum (IDLE, BUSY);
- mode constants PRIO_FIXED = 0 and PRIO_RR = 1.
REQ-024 SHALL instantiate one combinational sub-module prio_pick with parameter WIDTH:
- inputs: vector, ptr, mode;
- outputs: idx, any, onehot.
prio_pick SHALL be reusable standalone as the successor of the 8-to-3 encoder.
REQ-025 SHALL keep all sequential state (state, pending vector, ptr) in the top module.

Verification
REQ-026 SHALL cover MODE 0 / WIDTH 8 / req_i 8'b1010_0100 with out_ready_i held 1: beats idx 2, 5, 7; last_o only on idx 7; req_ready_o = 1 one cycle after the idx 7 beat.
REQ-027 SHALL cover backpressure, MODE 0 / req_i 8'b0000_0011 with out_ready_i low 3 cycles: idx_o stable at 0 for those cycles, then beats 0 and 1.
REQ-028 SHALL cover MODE 1 / WIDTH 8, first vector 8'b1000_0001 then 8'b1000_0001 again:
- first vector beats 0, 7; ptr wraps to 0;
- second vector beats 0, 7 again.
Separately, a vector 8'b0001_0001 issued with ptr = 3 SHALL give beats 4, 0.
REQ-029 SHALL cover req_i 0: exactly one beat with any_o = 0, idx_o = 0, last_o = 1.
REQ-030 SHALL cover WIDTH 5 / MODE 1 / req_i 5'b11111: beats 0, 1, 2, 3, 4, ptr = 0 afterwards; req_valid_i held 1 during BUSY causes no second capture.
REQ-031 SHALL cover rst_n pulsed low mid-vector (after beat 1 of 3): out_valid_o drops asynchronously, and no beats appear after release until a new vector is accepted.
